round_referee: RTL and testbench

ROUND_REFEREE -- requirements
Module: round_referee

---
 rtl/round_referee.sv | 140 ++++++++++++++
 tb/tb_round_referee.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// round_referee
//   Decides the outcome of one tank round. When the first tank is hit the
//   referee waits SETTLE_FRAMES video frames so that a bullet already in
//   flight can still destroy the other tank. After that wait it issues one
//   pulse: redwin, greenwin or draw.
//
// Parameters
//   SETTLE_FRAMES  frame_tick pulses between the first hit and the verdict (1..255)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   screenreset  high = round not running, low = round in play
//   frame_tick   one-cycle pulse per video frame
//   red_hit      red tank struck this cycle (level)
//   green_hit    green tank struck this cycle (level)
//   redwin       one-cycle pulse: red won
//   greenwin     one-cycle pulse: green won
//   draw         one-cycle pulse: both destroyed, round replayed
//   red_alive    red tank still drawn/controllable
//   green_alive  green tank still drawn/controllable
//   settling     high while waiting for late kills
module round_referee #(
  parameter int SETTLE_FRAMES = 60
) (
  input  logic clk,
  input  logic reset_n,
  input  logic screenreset,
  input  logic frame_tick,
  input  logic red_hit,
  input  logic green_hit,
  output logic redwin,
  output logic greenwin,
  output logic draw,
  output logic red_alive,
  output logic green_alive,
  output logic settling
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_DECLARE = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [7:0] LAST_FRAME = 8'(SETTLE_FRAMES - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       red_alive_q, red_alive_d;
  logic       green_alive_q, green_alive_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    red_alive_d   = red_alive_q;
    green_alive_d = green_alive_q;

    case (state_q)
      ST_IDLE: begin
        if (!screenreset) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (screenreset) begin
          state_d = ST_IDLE;
        end else if (red_hit || green_hit) begin
          // A frame_tick in the same cycle is not counted: the wait
          // starts from zero on entry to SETTLE.
          if (red_hit)   red_alive_d   = 1'b0;
          if (green_hit) green_alive_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (screenreset) begin
          state_d = ST_IDLE;
        end else begin
          // Late kills; clearing an already-cleared flag is harmless,
          // and the frame counter keeps running regardless.
          if (red_hit)   red_alive_d   = 1'b0;
          if (green_hit) green_alive_d = 1'b0;
          if (frame_tick) begin
            if (cnt_q == LAST_FRAME) begin
              cnt_d   = 8'd0;
              state_d = ST_DECLARE;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
      end

      ST_DECLARE: begin
        // The verdict pulse is this single cycle. A draw replays the
        // round; a pending screenreset also returns to IDLE.
        if (screenreset || (!red_alive_q && !green_alive_q)) state_d = ST_IDLE;
        else                                                 state_d = ST_DONE;
      end

      ST_DONE: begin
        if (screenreset) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Every way back into IDLE re-arms both tanks and the frame counter.
    if (state_d == ST_IDLE) begin
      red_alive_d   = 1'b1;
      green_alive_d = 1'b1;
      cnt_d         = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      red_alive_q   <= 1'b1;
      green_alive_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      red_alive_q   <= red_alive_d;
      green_alive_q <= green_alive_d;
    end
  end

  // Moore outputs: decoded only from registered state and flags.
  assign red_alive   = red_alive_q;
  assign green_alive = green_alive_q;
  assign settling    = (state_q == ST_SETTLE);
  assign redwin      = (state_q == ST_DECLARE) &&  red_alive_q && !green_alive_q;
  assign greenwin    = (state_q == ST_DECLARE) && !red_alive_q &&  green_alive_q;
  assign draw        = (state_q == ST_DECLARE) && !red_alive_q && !green_alive_q;

endmodule

// File: tb/tb_round_referee.sv
// tb_round_referee
//   Directed bench for round_referee with SETTLE_FRAMES=4. Inputs change 1ns
//   after a rising edge; outputs are checked at that same point, so they show
//   the state reached at that edge. Outputs are compared as one 6-bit vector
//   {red_alive, green_alive, settling, redwin, greenwin, draw}.
module tb_round_referee;

  logic clk = 1'b0;
  logic reset_n;
  logic screenreset;
  logic frame_tick;
  logic red_hit;
  logic green_hit;
  logic redwin, greenwin, draw, red_alive, green_alive, settling;

  int checks = 0;
  int errors = 0;

  round_referee #(.SETTLE_FRAMES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .screenreset(screenreset),
    .frame_tick (frame_tick),
    .red_hit    (red_hit),
    .green_hit  (green_hit),
    .redwin     (redwin),
    .greenwin   (greenwin),
    .draw       (draw),
    .red_alive  (red_alive),
    .green_alive(green_alive),
    .settling   (settling)
  );

  always #5 clk = ~clk;

  // Output vector bit order: {red_alive, green_alive, settling, redwin, greenwin, draw}
  localparam logic [5:0] O_IDLE    = 6'b110000;
  localparam logic [5:0] O_R_DEAD  = 6'b011000;
  localparam logic [5:0] O_G_DEAD  = 6'b101000;
  localparam logic [5:0] O_BOTH    = 6'b001000;
  localparam logic [5:0] O_GWIN    = 6'b010010;
  localparam logic [5:0] O_RWIN    = 6'b100100;
  localparam logic [5:0] O_DRAW    = 6'b000001;
  localparam logic [5:0] O_DONE_G  = 6'b010000;
  localparam logic [5:0] O_DONE_R  = 6'b100000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] expv);
    logic [5:0] obs;
    obs = {red_alive, green_alive, settling, redwin, greenwin, draw};
    checks++;
    assert (obs === expv)
      $display("check %-14s observed %b expected %b ok", tag, obs, expv);
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One frame_tick pulse, checking the outputs after the edge that saw it.
  task automatic ftick(input string tag, input logic [5:0] expv);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk(tag, expv);
  endtask

  initial begin
    reset_n = 1'b0; screenreset = 1'b1; frame_tick = 1'b0;
    red_hit = 1'b0; green_hit = 1'b0;
    step(); step();
    chk("reset", O_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("idle_hold", O_IDLE);

    // Red hit alone: green wins after 4 ticks, then DONE until screenreset.
    screenreset = 1'b0;
    step();                    chk("w_play", O_IDLE);
    red_hit = 1'b1; step(); red_hit = 1'b0;
    chk("w_settle", O_R_DEAD);
    ftick("w_tick1", O_R_DEAD);
    ftick("w_tick2", O_R_DEAD);
    ftick("w_tick3", O_R_DEAD);
    ftick("w_greenwin", O_GWIN);
    step();                    chk("w_done", O_DONE_G);
    step();                    chk("w_done_hold", O_DONE_G);
    screenreset = 1'b1;
    step();                    chk("w_idle", O_IDLE);

    // Simultaneous hits: draw, then IDLE and straight back into PLAY.
    screenreset = 1'b0;
    step();                    chk("d_play", O_IDLE);
    red_hit = 1'b1; green_hit = 1'b1; step(); red_hit = 1'b0; green_hit = 1'b0;
    chk("d_settle", O_BOTH);
    ftick("d_tick1", O_BOTH);
    ftick("d_tick2", O_BOTH);
    ftick("d_tick3", O_BOTH);
    ftick("d_draw", O_DRAW);
    step();                    chk("d_idle", O_IDLE);
    step();                    chk("d_replay", O_IDLE);

    // Late kill: green hit, red hit after 2 ticks; counter keeps running.
    green_hit = 1'b1; step(); green_hit = 1'b0;
    chk("l_settle", O_G_DEAD);
    ftick("l_tick1", O_G_DEAD);
    ftick("l_tick2", O_G_DEAD);
    red_hit = 1'b1; step(); red_hit = 1'b0;
    chk("l_latekill", O_BOTH);
    ftick("l_tick3", O_BOTH);
    ftick("l_draw", O_DRAW);
    step();                    chk("l_idle", O_IDLE);
    step();                    chk("l_replay", O_IDLE);

    // Abort during SETTLE: no pulse, alive flags restored.
    green_hit = 1'b1; step(); green_hit = 1'b0;
    chk("a_settle", O_G_DEAD);
    ftick("a_tick1", O_G_DEAD);
    screenreset = 1'b1;
    step();                    chk("a_idle", O_IDLE);
    for (int i = 0; i < 5; i++) ftick("a_quiet", O_IDLE);

    // Hits in IDLE are ignored.
    red_hit = 1'b1; green_hit = 1'b1;
    step();                    chk("i_hits", O_IDLE);
    step();                    chk("i_hits2", O_IDLE);
    red_hit = 1'b0; green_hit = 1'b0;

    // Hit with a simultaneous tick: the tick is not counted, so 4 more ticks needed.
    screenreset = 1'b0;
    step();                    chk("t_play", O_IDLE);
    green_hit = 1'b1; frame_tick = 1'b1; step(); green_hit = 1'b0; frame_tick = 1'b0;
    chk("t_settle", O_G_DEAD);
    ftick("t_tick1", O_G_DEAD);
    ftick("t_tick2", O_G_DEAD);
    ftick("t_tick3", O_G_DEAD);
    ftick("t_redwin", O_RWIN);
    step();                    chk("t_done", O_DONE_R);
    // Hits in DONE are ignored.
    red_hit = 1'b1; green_hit = 1'b1;
    step();                    chk("x_hits", O_DONE_R);
    step();                    chk("x_hits2", O_DONE_R);
    red_hit = 1'b0; green_hit = 1'b0;
    screenreset = 1'b1;
    step();                    chk("x_idle", O_IDLE);

    // Asynchronous reset mid-SETTLE, between clock edges.
    screenreset = 1'b0;
    step();                    chk("r_play", O_IDLE);
    red_hit = 1'b1; step(); red_hit = 1'b0;
    chk("r_settle", O_R_DEAD);
    ftick("r_tick1", O_R_DEAD);
    ftick("r_tick2", O_R_DEAD);
    #2;
    reset_n = 1'b0;
    #1;
    chk("r_async", O_IDLE);
    for (int i = 0; i < 3; i++) ftick("r_held", O_IDLE);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) ftick("r_after", O_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
